// File: rtl/rx_link_if.sv
// Byte-level signals between the serial-to-parallel converter, the lane
// sequencer and downstream logic. The master side drives the converter bytes.
interface rx_link_if;
    logic [7:0] rx_byte;
    logic       rx_byte_vld;
    logic       rx_err;
    logic       sp_enable;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       link_idle;
    logic       lock_lost;
    logic [1:0] state;

    modport master (
        output rx_byte, rx_byte_vld, rx_err,
        input  sp_enable, data_out, valid_out, active, link_idle, lock_lost, state
    );

    modport slave (
        input  rx_byte, rx_byte_vld, rx_err,
        output sp_enable, data_out, valid_out, active, link_idle, lock_lost, state
    );
endinterface

// File: rtl/rx_link_sequencer.sv
// Receive lane sequencer: holds the converter off after reset, acquires COM
// symbol lock, forwards data bytes, tracks IDLE periods and drops lock on errors.
module rx_link_sequencer #(
    parameter logic [7:0] COM_SYM    = 8'hBC,
    parameter int         RST_CYCLES = 8,
    parameter int         LOCK_CNT   = 4,
    parameter int         IDLE_CNT   = 4,
    parameter int         ERR_MAX    = 3
) (
    input  logic         clk4f,
    input  logic         reset,
    rx_link_if.slave     bus
);
    localparam int RST_W  = $clog2(RST_CYCLES) + 1;
    localparam int COM_W  = $clog2(LOCK_CNT) + 1;
    localparam int IDLE_W = $clog2(IDLE_CNT) + 1;
    localparam int ERR_W  = $clog2(ERR_MAX) + 1;

    localparam logic [RST_W-1:0]  RST_TGT  = RST_W'(RST_CYCLES - 1);
    localparam logic [COM_W-1:0]  LOCK_TGT = COM_W'(LOCK_CNT);
    localparam logic [IDLE_W-1:0] IDLE_TGT = IDLE_W'(IDLE_CNT);
    localparam logic [ERR_W-1:0]  ERR_TGT  = ERR_W'(ERR_MAX);

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_SEARCH = 2'd1,
        S_ACTIVE = 2'd2,
        S_IDLE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [COM_W-1:0]   r_com_cnt;
    logic [IDLE_W-1:0]  r_idle_cnt;
    logic [ERR_W-1:0]   r_err_cnt;
    logic               r_sp_enable;
    logic [7:0]         r_data_out;
    logic               r_valid_out;
    logic               r_active;
    logic               r_link_idle;
    logic               r_lock_lost;

    state_t             w_state_next;
    logic [RST_W-1:0]   w_rst_cnt_next;
    logic [COM_W-1:0]   w_com_cnt_next;
    logic [IDLE_W-1:0]  w_idle_cnt_next;
    logic [ERR_W-1:0]   w_err_cnt_next;
    logic [7:0]         w_data_next;
    logic               w_valid_next;
    logic               w_lost_next;

    logic               w_good_com;
    logic [RST_W-1:0]   w_rst_inc;
    logic [COM_W-1:0]   w_com_inc;
    logic [IDLE_W-1:0]  w_idle_inc;
    logic [ERR_W-1:0]   w_err_inc;

    // rx_err outranks the byte value, so an errored COM is never a good COM.
    assign w_good_com = !bus.rx_err && (bus.rx_byte == COM_SYM);

    // Saturating increments: counters hold at all-ones instead of wrapping.
    assign w_rst_inc  = (r_rst_cnt  == '1) ? r_rst_cnt  : r_rst_cnt  + 1'b1;
    assign w_com_inc  = (r_com_cnt  == '1) ? r_com_cnt  : r_com_cnt  + 1'b1;
    assign w_idle_inc = (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + 1'b1;
    assign w_err_inc  = (r_err_cnt  == '1) ? r_err_cnt  : r_err_cnt  + 1'b1;

    always_comb begin
        w_state_next    = r_state;
        w_rst_cnt_next  = r_rst_cnt;
        w_com_cnt_next  = r_com_cnt;
        w_idle_cnt_next = r_idle_cnt;
        w_err_cnt_next  = r_err_cnt;
        w_data_next     = r_data_out;
        w_valid_next    = 1'b0;
        w_lost_next     = 1'b0;

        case (r_state)
            S_RESET: begin
                if (r_rst_cnt == RST_TGT) begin
                    w_state_next   = S_SEARCH;
                    w_rst_cnt_next = '0;
                end else begin
                    w_rst_cnt_next = w_rst_inc;
                end
            end
            S_SEARCH: begin
                if (bus.rx_byte_vld) begin
                    if (!w_good_com) begin
                        w_com_cnt_next = '0;
                    end else if (w_com_inc == LOCK_TGT) begin
                        w_state_next   = S_ACTIVE;
                        w_com_cnt_next = '0;
                    end else begin
                        w_com_cnt_next = w_com_inc;
                    end
                end
            end
            S_ACTIVE, S_IDLE: begin
                if (bus.rx_byte_vld) begin
                    if (bus.rx_err) begin
                        // Errors leave idle_cnt alone unless they cost the lock.
                        if (w_err_inc == ERR_TGT) begin
                            w_state_next    = S_SEARCH;
                            w_lost_next     = 1'b1;
                            w_err_cnt_next  = '0;
                            w_idle_cnt_next = '0;
                            w_com_cnt_next  = '0;
                        end else begin
                            w_err_cnt_next = w_err_inc;
                        end
                    end else begin
                        w_err_cnt_next = '0;
                        if (!w_good_com) begin
                            w_data_next     = bus.rx_byte;
                            w_valid_next    = 1'b1;
                            w_idle_cnt_next = '0;
                            w_state_next    = S_ACTIVE;
                        end else if (r_state == S_ACTIVE) begin
                            if (w_idle_inc == IDLE_TGT) begin
                                w_state_next    = S_IDLE;
                                w_idle_cnt_next = '0;
                            end else begin
                                w_idle_cnt_next = w_idle_inc;
                            end
                        end
                    end
                end
            end
            default: w_state_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk4f or negedge reset) begin
        if (!reset) begin
            r_state     <= S_RESET;
            r_rst_cnt   <= '0;
            r_com_cnt   <= '0;
            r_idle_cnt  <= '0;
            r_err_cnt   <= '0;
            r_sp_enable <= 1'b0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_active    <= 1'b0;
            r_link_idle <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rst_cnt   <= w_rst_cnt_next;
            r_com_cnt   <= w_com_cnt_next;
            r_idle_cnt  <= w_idle_cnt_next;
            r_err_cnt   <= w_err_cnt_next;
            r_sp_enable <= (w_state_next != S_RESET);
            r_data_out  <= w_data_next;
            r_valid_out <= w_valid_next;
            r_active    <= (w_state_next == S_ACTIVE) || (w_state_next == S_IDLE);
            r_link_idle <= (w_state_next == S_IDLE);
            r_lock_lost <= w_lost_next;
        end
    end

    assign bus.sp_enable = r_sp_enable;
    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign bus.active    = r_active;
    assign bus.link_idle = r_link_idle;
    assign bus.lock_lost = r_lock_lost;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_rx_link_sequencer.sv
// Bench for rx_link_sequencer: directed lock/idle/error/reset sequences and a
// random byte stream, every cycle compared against a per-byte behavioural model.
module tb_rx_link_sequencer;
    localparam logic [7:0] COM = 8'hBC;
    localparam int RST_CYC = 8;
    localparam int LOCK_N  = 4;
    localparam int IDLE_N  = 4;
    localparam int ERR_N   = 3;

    logic clk4f = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn = 0;

    rx_link_if bus ();

    rx_link_sequencer dut (
        .clk4f (clk4f),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk4f = ~clk4f;

    // Reference model: mode is 0=RESET 1=SEARCH 2=ACTIVE 3=IDLE.
    int         m_mode, m_wait, m_coms, m_idles, m_errs;
    logic [7:0] m_data;
    logic       m_fwd, m_lost;

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_coms = 0; m_idles = 0; m_errs = 0;
        m_data = 8'h00; m_fwd = 1'b0; m_lost = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic v, input logic e);
        m_fwd  = 1'b0;
        m_lost = 1'b0;
        if (m_mode == 0) begin
            if (m_wait == RST_CYC - 1) m_mode = 1;
            else m_wait++;
        end else if (v) begin
            if (m_mode == 1) begin
                m_coms = (!e && b == COM) ? m_coms + 1 : 0;
                if (m_coms == LOCK_N) begin m_mode = 2; m_coms = 0; end
            end else if (e) begin
                m_errs++;
                if (m_errs == ERR_N) begin
                    m_mode = 1; m_lost = 1'b1; m_errs = 0; m_idles = 0; m_coms = 0;
                end
            end else begin
                m_errs = 0;
                if (b != COM) begin
                    m_data = b; m_fwd = 1'b1; m_idles = 0; m_mode = 2;
                end else if (m_mode == 2) begin
                    m_idles++;
                    if (m_idles == IDLE_N) begin m_mode = 3; m_idles = 0; end
                end
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".state"},     32'(bus.state),     32'(m_mode));
        check_eq({tag, ".sp_enable"}, 32'(bus.sp_enable), 32'(m_mode != 0));
        check_eq({tag, ".active"},    32'(bus.active),    32'(m_mode >= 2));
        check_eq({tag, ".link_idle"}, 32'(bus.link_idle), 32'(m_mode == 3));
        check_eq({tag, ".lock_lost"}, 32'(bus.lock_lost), 32'(m_lost));
        check_eq({tag, ".valid_out"}, 32'(bus.valid_out), 32'(m_fwd));
        check_eq({tag, ".data_out"},  32'(bus.data_out),  32'(m_data));
    endtask

    // One transaction: present inputs at the falling edge, clock once, compare.
    task automatic drive(input logic [7:0] b, input logic v, input logic e);
        bus.rx_byte     = b;
        bus.rx_byte_vld = v;
        bus.rx_err      = e;
        @(posedge clk4f);
        model_byte(b, v, e);
        @(negedge clk4f);
        n_txn++;
        $display("txn %0d: byte=%h vld=%b err=%b -> state=%0d sp=%b vout=%b data=%h lost=%b",
                 n_txn, b, v, e, bus.state, bus.sp_enable, bus.valid_out, bus.data_out, bus.lock_lost);
        compare_all("txn");
    endtask

    task automatic relock();
        for (int i = 0; i < LOCK_N; i++) drive(COM, 1'b1, 1'b0);
    endtask

    initial begin
        bus.rx_byte = 8'h00; bus.rx_byte_vld = 1'b0; bus.rx_err = 1'b0;
        model_reset();
        repeat (2) @(negedge clk4f);
        compare_all("in_reset");
        reset = 1'b1;

        for (int i = 1; i <= RST_CYC; i++) begin
            drive(8'h00, 1'b0, 1'b0);
            check_eq("sp_en_release", 32'(bus.sp_enable), 32'(i == RST_CYC));
        end
        check_eq("search_state", 32'(bus.state), 32'd1);

        // Broken COM run: no lock until four uninterrupted COMs.
        for (int i = 0; i < 3; i++) drive(COM, 1'b1, 1'b0);
        check_eq("no_lock_3com", 32'(bus.active), 32'd0);
        drive(8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(COM, 1'b1, 1'b0);
        check_eq("no_lock_after_break", 32'(bus.state), 32'd1);
        drive(COM, 1'b1, 1'b0);
        check_eq("lock_state", 32'(bus.state), 32'd2);
        check_eq("lock_vout", 32'(bus.valid_out), 32'd0);

        drive(8'h12, 1'b1, 1'b0);
        check_eq("fwd_12", 32'(bus.data_out), 32'h12);
        drive(8'h34, 1'b1, 1'b0);
        check_eq("fwd_34", 32'(bus.data_out), 32'h34);
        relock();
        check_eq("idle_state", 32'(bus.state), 32'd3);
        drive(8'h56, 1'b1, 1'b0);
        check_eq("idle_exit_state", 32'(bus.state), 32'd2);
        check_eq("idle_exit_data", 32'(bus.data_out), 32'h56);

        // Errored COM must not count as COM; three errors lose lock.
        drive(COM, 1'b1, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h9E, 1'b1, 1'b1);
        drive(8'h11, 1'b1, 1'b1);
        check_eq("lost_pulse", 32'(bus.lock_lost), 32'd1);
        drive(8'h00, 1'b0, 1'b0);
        check_eq("lost_one_cycle", 32'(bus.lock_lost), 32'd0);
        drive(8'h22, 1'b1, 1'b1);
        check_eq("search_err_no_pulse", 32'(bus.lock_lost), 32'd0);

        relock();
        drive(8'h01, 1'b1, 1'b1);
        drive(8'h02, 1'b1, 1'b1);
        drive(8'h77, 1'b1, 1'b0);
        check_eq("err_recover_data", 32'(bus.data_out), 32'h77);
        drive(8'h03, 1'b1, 1'b1);
        drive(8'h04, 1'b1, 1'b1);
        check_eq("err_cnt_cleared", 32'(bus.active), 32'd1);

        // Asynchronous reset while locked, then the release sequence again.
        bus.rx_byte_vld = 1'b0;
        @(posedge clk4f);
        model_byte(bus.rx_byte, 1'b0, 1'b0);
        #3 reset = 1'b0;
        #1 model_reset();
        compare_all("async_rst");
        check_eq("async_rst_sp", 32'(bus.sp_enable), 32'd0);
        repeat (2) @(negedge clk4f);
        compare_all("async_hold");
        reset = 1'b1;
        for (int i = 1; i <= RST_CYC; i++) begin
            drive(8'h00, 1'b0, 1'b0);
            check_eq("sp_en_rerelease", 32'(bus.sp_enable), 32'(i == RST_CYC));
        end

        // Random stream weighted toward COM so lock, idle and loss all occur.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] b;
            logic       v, e;
            v = ($urandom_range(0, 7) != 0);
            e = ($urandom_range(0, 11) == 0);
            b = ($urandom_range(0, 2) != 0) ? COM : 8'($urandom_range(0, 255));
            drive(b, v, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
